fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_reader_buf.sv | 54 +++++
 rtl/fifo_reader.sv | 109 ++++++++++
 tb/tb_fifo_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared width defaults and the reader state encoding used by the
// fifo_reader block and its output buffer.
package fifo_pkg;

    localparam int F_WIDTH_DEF = 8;
    localparam int L_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } reader_state_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order skid buffer between the upstream read data and the
// downstream valid/ready port.
module fifo_reader_buf
    import fifo_pkg::*;
#(
    parameter int W = F_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         valid,
    input  logic         ready,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         xfer;

    assign xfer      = valid & ready;
    assign valid     = (count != 2'd0);
    assign occupancy = count;
    // Data is forced to zero when empty so stale words never leak out.
    assign rd_data   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls len words from an upstream FIFO with one-cycle read
// latency and streams them out over a valid/ready port.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int F_WIDTH = F_WIDTH_DEF,
    parameter int L_WIDTH = L_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [L_WIDTH-1:0] len,
    input  logic               fifo_empty,
    input  logic [F_WIDTH-1:0] fifo_dout,
    output logic               fifo_deq,
    output logic [F_WIDTH-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic               done
);

    reader_state_t      state;
    logic [L_WIDTH-1:0] len_q;
    logic [L_WIDTH-1:0] issued;
    logic [L_WIDTH-1:0] sent;
    logic               inflight;
    logic [1:0]         occupancy;
    logic               xfer;
    logic               last_xfer;
    logic [2:0]         committed;

    assign xfer      = m_valid & m_ready;
    assign last_xfer = xfer && (sent == len_q - 1'b1);

    // Buffer slots already spoken for: words held after this cycle's
    // downstream transfer plus the read still in flight. Counting the
    // departing word as free is what sustains one word per cycle.
    assign committed = {1'b0, occupancy} - {2'b00, xfer} + {2'b00, inflight};

    assign fifo_deq = !rst && (state == RUN) && !fifo_empty
                      && (issued < len_q) && (committed < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= fifo_deq;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        issued <= '0;
                        sent   <= '0;
                        if (len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_deq) begin
                        issued <= issued + 1'b1;
                    end
                    if (xfer) begin
                        sent <= sent + 1'b1;
                    end
                    if (last_xfer) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    fifo_reader_buf #(
        .W(F_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (inflight),
        .wr_data  (fifo_dout),
        .rd_data  (m_data),
        .valid    (m_valid),
        .ready    (m_ready),
        .occupancy(occupancy)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader paired with a small 4-deep, 8-bit FIFO
// model; inputs change on the falling edge, outputs are checked 1 unit later.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_deq;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;

    logic       enq;
    logic [7:0] enq_data;
    logic [7:0] fmem [4];
    logic [1:0] frd;
    logic [1:0] fwr;
    logic [2:0] fcount;

    int total = 0;
    int bad = 0;

    int deq_count = 0;
    int xfer_count = 0;
    int done_count = 0;
    int valid_count = 0;
    int empty_deq_count = 0;
    int max_outstanding = 0;
    logic [7:0] got [$];
    logic mon_clear = 1'b0;

    always #5 clk = ~clk;

    fifo_reader #(
        .F_WIDTH(8),
        .L_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_deq  (fifo_deq),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    // Upstream FIFO: F_DEPTH=4, dout registered on an accepted deq.
    assign fifo_empty = (fcount == 3'd0);

    always @(posedge clk) begin
        if (rst) begin
            fcount    <= 3'd0;
            frd       <= 2'd0;
            fwr       <= 2'd0;
            fifo_dout <= 8'h00;
        end else begin
            if (enq) begin
                fmem[fwr] <= enq_data;
                fwr       <= fwr + 2'd1;
            end
            if (fifo_deq && fcount != 3'd0) begin
                fifo_dout <= fmem[frd];
                frd       <= frd + 2'd1;
            end
            fcount <= fcount + (enq ? 3'd1 : 3'd0)
                      - ((fifo_deq && fcount != 3'd0) ? 3'd1 : 3'd0);
        end
    end

    // Port activity recorder, sampled well after inputs settle each cycle.
    always @(negedge clk) begin
        #2;
        if (mon_clear) begin
            deq_count       = 0;
            xfer_count      = 0;
            done_count      = 0;
            valid_count     = 0;
            empty_deq_count = 0;
            max_outstanding = 0;
            got.delete();
        end else begin
            if (fifo_deq) deq_count++;
            if (fifo_deq && fifo_empty) empty_deq_count++;
            if (m_valid) valid_count++;
            if (m_valid && m_ready) begin
                xfer_count++;
                got.push_back(m_data);
            end
            if (done) done_count++;
            if (deq_count - xfer_count > max_outstanding)
                max_outstanding = deq_count - xfer_count;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; len = 8'd0; m_ready = 1'b0; enq = 1'b0; enq_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge clk);
        enq = 1'b1; enq_data = v;
    endtask

    task automatic clear_monitor();
        @(negedge clk);
        enq = 1'b0; mon_clear = 1'b1;
        @(negedge clk);
        mon_clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; len = 8'd5; m_ready = 1'b1; enq = 1'b0; enq_data = 8'h00;
        #1;
        total++; if (fifo_deq !== 1'b0) begin bad++; $display("[TB] FAIL reset_deq_during_rst: got %b expected 0", fifo_deq); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_m_data: got %h expected 00", m_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_start_ignored: busy got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        do_reset();
        push(8'd3); push(8'd7); push(8'd9);
        clear_monitor();
        @(negedge clk); start = 1'b1; len = 8'd3; m_ready = 1'b1; #1;
        total++; if (fifo_deq !== 1'b0) begin bad++; $display("[TB] FAIL basic_c0_deq: got %b expected 0", fifo_deq); end
        @(negedge clk); start = 1'b0; #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_c1_busy: got %b expected 1", busy); end
        total++; if (fifo_deq !== 1'b1) begin bad++; $display("[TB] FAIL basic_c1_deq: got %b expected 1", fifo_deq); end
        @(negedge clk); #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_c2_valid: got %b expected 0", m_valid); end
        total++; if (fifo_deq !== 1'b1) begin bad++; $display("[TB] FAIL basic_c2_deq: got %b expected 1", fifo_deq); end
        @(negedge clk); #1;
        total++; if (m_valid !== 1'b1 || m_data !== 8'd3) begin bad++; $display("[TB] FAIL basic_c3_word: got v=%b d=%0d expected v=1 d=3", m_valid, m_data); end
        total++; if (fifo_deq !== 1'b1) begin bad++; $display("[TB] FAIL basic_c3_deq: got %b expected 1", fifo_deq); end
        @(negedge clk); #1;
        total++; if (m_valid !== 1'b1 || m_data !== 8'd7) begin bad++; $display("[TB] FAIL basic_c4_word: got v=%b d=%0d expected v=1 d=7", m_valid, m_data); end
        total++; if (fifo_deq !== 1'b0) begin bad++; $display("[TB] FAIL basic_c4_deq: got %b expected 0", fifo_deq); end
        @(negedge clk); #1;
        total++; if (m_valid !== 1'b1 || m_data !== 8'd9) begin bad++; $display("[TB] FAIL basic_c5_word: got v=%b d=%0d expected v=1 d=9", m_valid, m_data); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_c5_done: got %b expected 0", done); end
        @(negedge clk); #1;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_c6_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_c6_valid: got %b expected 0", m_valid); end
        @(negedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_c7_done: got %b expected 0", done); end
        total++; if (deq_count != 3) begin bad++; $display("[TB] FAIL basic_deq_count: got %0d expected 3", deq_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_words [4];
        int waited;
        exp_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        clear_monitor();
        @(negedge clk); start = 1'b1; len = 8'd4; m_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk); m_ready = 1'b0; #1;
            total++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin bad++; $display("[TB] FAIL bp_hold_c%0d: got v=%b d=%h expected v=1 d=11", c, m_valid, m_data); end
            total++; if (fifo_deq !== 1'b0) begin bad++; $display("[TB] FAIL bp_deq_c%0d: got %b expected 0", c, fifo_deq); end
        end
        @(negedge clk); m_ready = 1'b1;
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL bp_done_timeout: done got %b expected 1 within 20 cycles", done); end
        total++; if (got.size() != 4) begin bad++; $display("[TB] FAIL bp_word_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_words[i]) begin bad++; $display("[TB] FAIL bp_word%0d: got %h expected %h", i, got[i], exp_words[i]); end
        end
        total++; if (deq_count != 4) begin bad++; $display("[TB] FAIL bp_deq_count: got %0d expected 4", deq_count); end
        total++; if (max_outstanding > 2) begin bad++; $display("[TB] FAIL bp_outstanding: got %0d expected <=2", max_outstanding); end
    endtask

    task automatic test_empty_stall();
        do_reset();
        clear_monitor();
        @(negedge clk); start = 1'b1; len = 8'd2; m_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start    = 1'b0;
            enq      = (c == 5) || (c == 9);
            enq_data = (c == 5) ? 8'h55 : 8'hAA;
            #1;
            if (c == 5) begin
                total++; if (fifo_deq !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL empty_c5: got deq=%b busy=%b expected deq=0 busy=1", fifo_deq, busy); end
            end
            if (c == 8) begin
                total++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin bad++; $display("[TB] FAIL empty_c8_word: got v=%b d=%h expected v=1 d=55", m_valid, m_data); end
            end
            if (c == 12) begin
                total++; if (m_valid !== 1'b1 || m_data !== 8'hAA) begin bad++; $display("[TB] FAIL empty_c12_word: got v=%b d=%h expected v=1 d=aa", m_valid, m_data); end
            end
        end
        total++; if (empty_deq_count != 0) begin bad++; $display("[TB] FAIL empty_deq_while_empty: got %0d expected 0", empty_deq_count); end
        total++; if (got.size() != 2) begin bad++; $display("[TB] FAIL empty_word_count: got %0d expected 2", got.size()); end
        if (got.size() == 2) begin
            total++; if (got[0] !== 8'h55 || got[1] !== 8'hAA) begin bad++; $display("[TB] FAIL empty_words: got %h,%h expected 55,aa", got[0], got[1]); end
        end
        total++; if (done_count != 1) begin bad++; $display("[TB] FAIL empty_done_count: got %0d expected 1", done_count); end
    endtask

    task automatic test_zero_len();
        do_reset();
        push(8'h99);
        clear_monitor();
        @(negedge clk); start = 1'b1; len = 8'd0; m_ready = 1'b1; #1;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL zero_c0_done: got %b expected 0", done); end
        @(negedge clk); start = 1'b0; #1;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_c1_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        @(negedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL zero_c2_done: got %b expected 0", done); end
        repeat (4) @(negedge clk);
        total++; if (deq_count != 0) begin bad++; $display("[TB] FAIL zero_deq_count: got %0d expected 0", deq_count); end
        total++; if (valid_count != 0) begin bad++; $display("[TB] FAIL zero_valid_count: got %0d expected 0", valid_count); end
        total++; if (done_count != 1) begin bad++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_count); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        clear_monitor();
        @(negedge clk); start = 1'b1; len = 8'd4; m_ready = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        total++; if (fifo_deq !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_first_deq: got %b expected 1", fifo_deq); end
        @(negedge clk); rst = 1'b1; #1;
        total++; if (fifo_deq !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_deq_in_rst: got %b expected 0", fifo_deq); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (fifo_deq !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_outputs: got deq=%b v=%b d=%h expected 0,0,00", fifo_deq, m_valid, m_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_state: got busy=%b done=%b expected 0,0", busy, done); end
        repeat (5) @(negedge clk);
        total++; if (done_count != 0) begin bad++; $display("[TB] FAIL rstmid_done_count: got %0d expected 0", done_count); end
        total++; if (valid_count != 0) begin bad++; $display("[TB] FAIL rstmid_valid_count: got %0d expected 0", valid_count); end
    endtask

    task automatic test_start_ignored();
        int waited;
        do_reset();
        push(8'h01); push(8'h02); push(8'h03);
        clear_monitor();
        @(negedge clk); start = 1'b1; len = 8'd3; m_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; len = 8'd1;
        @(negedge clk); start = 1'b0; len = 8'd0; #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ign_busy: got %b expected 1", busy); end
        waited = 0;
        while (done !== 1'b1 && waited < 15) begin
            @(negedge clk); #1;
            waited++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL ign_done_timeout: done got %b expected 1 within 15 cycles", done); end
        repeat (3) @(negedge clk);
        total++; if (got.size() != 3) begin bad++; $display("[TB] FAIL ign_word_count: got %0d expected 3", got.size()); end
        if (got.size() == 3) begin
            total++; if (got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03) begin bad++; $display("[TB] FAIL ign_words: got %h,%h,%h expected 01,02,03", got[0], got[1], got[2]); end
        end
        total++; if (deq_count != 3) begin bad++; $display("[TB] FAIL ign_deq_count: got %0d expected 3", deq_count); end
        total++; if (done_count != 1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ign_after: got done_count=%0d busy=%b expected 1,0", done_count, busy); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; m_ready = 1'b0; enq = 1'b0; enq_data = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_zero_len();
        test_reset_mid_burst();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
